// File: rtl/dcache_pkg.sv
// Shared definitions for the L1 data cache: request/response bus layout,
// MA control bit positions and FSM state encodings.
package dcache_pkg;

  // MA control field bits
  localparam int unsigned MA_EN = 0;
  localparam int unsigned MA_RW = 1;  // 1 = write

  // Request bus {addr, wdata, MA}
  localparam int unsigned BUS_IN_W      = 66;
  localparam int unsigned BUS_MA_LSB    = 0;
  localparam int unsigned BUS_MA_MSB    = 1;
  localparam int unsigned BUS_WDATA_LSB = 2;
  localparam int unsigned BUS_WDATA_MSB = 33;
  localparam int unsigned BUS_ADDR_LSB  = 34;
  localparam int unsigned BUS_ADDR_MSB  = 65;

  // Response bus {miss, rdata}
  localparam int unsigned BUS_OUT_W    = 33;
  localparam int unsigned BUS_MISS_BIT = 32;

  // Controller FSM states
  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRefill = 2'd1;
  localparam logic [1:0] StWrite  = 2'd2;
  localparam logic [1:0] StWdone  = 2'd3;

endpackage

// File: rtl/dcache_line_ram.sv
// Tag, valid and data storage for a direct-mapped cache. Reads are
// combinational; word writes and tag/valid sets are synchronous. Only the
// valid bits are reset, which is enough to make every line miss.
module dcache_line_ram
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_BITS  = 4,
  parameter int unsigned OFFSET_BITS = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TAG_W       = ADDR_W - INDEX_BITS - OFFSET_BITS - 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // Lookup port
  input  logic [INDEX_BITS-1:0]  rd_index,
  input  logic [OFFSET_BITS-1:0] rd_offset,
  output logic [TAG_W-1:0]       rd_tag,
  output logic                   rd_valid,
  output logic [ADDR_W-1:0]      rd_word,
  // Word write port
  input  logic                   wr_en,
  input  logic [INDEX_BITS-1:0]  wr_index,
  input  logic [OFFSET_BITS-1:0] wr_offset,
  input  logic [ADDR_W-1:0]      wr_word,
  // Tag install port (marks the line valid)
  input  logic                   set_en,
  input  logic [INDEX_BITS-1:0]  set_index,
  input  logic [TAG_W-1:0]       set_tag
);

  localparam int unsigned NumLines = 1 << INDEX_BITS;
  localparam int unsigned NumWords = NumLines << OFFSET_BITS;

  logic [TAG_W-1:0]  tag_q  [NumLines];
  logic [ADDR_W-1:0] data_q [NumWords];
  logic [NumLines-1:0] valid_q;

  // Combinational lookup
  always_comb begin
    rd_tag   = tag_q[rd_index];
    rd_valid = valid_q[rd_index];
    rd_word  = data_q[{rd_index, rd_offset}];
  end

  // Valid bits: cleared asynchronously, set when a refill completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (set_en) begin
      valid_q[set_index] <= 1'b1;
    end
  end

  // Tag array, written together with the valid bit
  always_ff @(posedge clk) begin
    if (set_en) begin
      tag_q[set_index] <= set_tag;
    end
  end

  // Data array, one word per write
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[{wr_index, wr_offset}] <= wr_word;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache controller.
// Read hits return in the same cycle; misses refill a whole line one word at
// a time over a req/ack port; stores always write through and stall until
// the memory acknowledges.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_BITS  = 4,
  parameter int unsigned OFFSET_BITS = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [BUS_IN_W-1:0]  Dcache_bus_in,
  output logic [BUS_OUT_W-1:0] Dcache_bus_out,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [ADDR_W-1:0]    mem_wdata,
  input  logic [ADDR_W-1:0]    mem_rdata,
  input  logic                 mem_ack
);

  localparam int unsigned TAG_W = ADDR_W - INDEX_BITS - OFFSET_BITS - 2;

  // Request decode
  logic [1:0]             ma;
  logic                   req_en;
  logic                   req_rw;
  logic [ADDR_W-1:0]      req_addr;
  logic [ADDR_W-1:0]      req_wdata;
  logic [OFFSET_BITS-1:0] req_offset;
  logic [INDEX_BITS-1:0]  req_index;
  logic [TAG_W-1:0]       req_tag;
  logic                   unused_addr_lsbs;

  assign ma         = Dcache_bus_in[BUS_MA_MSB:BUS_MA_LSB];
  assign req_en     = ma[MA_EN];
  assign req_rw     = ma[MA_RW];
  assign req_addr   = Dcache_bus_in[BUS_ADDR_MSB:BUS_ADDR_LSB];
  assign req_wdata  = Dcache_bus_in[BUS_WDATA_MSB:BUS_WDATA_LSB];
  assign req_offset = req_addr[OFFSET_BITS+1:2];
  assign req_index  = req_addr[OFFSET_BITS+2 +: INDEX_BITS];
  assign req_tag    = req_addr[ADDR_W-1 -: TAG_W];
  assign unused_addr_lsbs = ^req_addr[1:0];

  // Line storage
  logic [TAG_W-1:0]       rd_tag;
  logic                   rd_valid;
  logic [ADDR_W-1:0]      rd_word;
  logic                   hit;
  logic                   ram_wr_en;
  logic [OFFSET_BITS-1:0] ram_wr_offset;
  logic [ADDR_W-1:0]      ram_wr_word;
  logic                   ram_set_en;

  assign hit = rd_valid && (rd_tag == req_tag);

  dcache_line_ram #(
    .INDEX_BITS  (INDEX_BITS),
    .OFFSET_BITS (OFFSET_BITS),
    .ADDR_W      (ADDR_W),
    .TAG_W       (TAG_W)
  ) u_line_ram (
    .clk       (Clk),
    .rst_n     (Rst),
    .rd_index  (req_index),
    .rd_offset (req_offset),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_word   (rd_word),
    .wr_en     (ram_wr_en),
    .wr_index  (req_index),
    .wr_offset (ram_wr_offset),
    .wr_word   (ram_wr_word),
    .set_en    (ram_set_en),
    .set_index (req_index),
    .set_tag   (req_tag)
  );

  // Controller state
  logic [1:0]             state_q, state_d;
  logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
  logic                   fill_done_q, fill_done_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]      mem_wdata_q, mem_wdata_d;
  logic                   miss;
  logic [ADDR_W-1:0]      rdata;

  // Next-state, memory port and pipeline response
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fill_done_d   = fill_done_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    ram_wr_en     = 1'b0;
    ram_wr_offset = req_offset;
    ram_wr_word   = req_wdata;
    ram_set_en    = 1'b0;
    miss          = 1'b0;
    rdata         = '0;

    unique case (state_q)
      StIdle: begin
        if (req_en) begin
          if (req_rw) begin
            miss        = 1'b1;
            state_d     = StWrite;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = req_wdata;
          end else if (hit) begin
            rdata = rd_word;
          end else begin
            miss        = 1'b1;
            state_d     = StRefill;
            cnt_d       = '0;
            fill_done_d = 1'b0;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = {req_tag, req_index, {OFFSET_BITS{1'b0}}, 2'b00};
          end
        end
      end

      StRefill: begin
        miss = 1'b1;
        if (fill_done_q) begin
          // Install the tag one cycle after the last word lands, so the
          // line only becomes visible once all of its data is written.
          ram_set_en  = 1'b1;
          fill_done_d = 1'b0;
          state_d     = StIdle;
        end else if (mem_ack) begin
          ram_wr_en     = 1'b1;
          ram_wr_offset = cnt_q;
          ram_wr_word   = mem_rdata;
          if (cnt_q == {OFFSET_BITS{1'b1}}) begin
            cnt_d       = '0;
            mem_req_d   = 1'b0;
            fill_done_d = 1'b1;
          end else begin
            cnt_d      = cnt_q + 1'b1;
            mem_addr_d = mem_addr_q + ADDR_W'(4);
          end
        end
      end

      StWrite: begin
        miss = 1'b1;
        if (mem_ack) begin
          // Write-through: keep a resident line coherent, never allocate
          ram_wr_en = hit;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = StWdone;
        end
      end

      StWdone: begin
        // Store retires; no lookup this cycle
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Controller registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      fill_done_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_done_q <= fill_done_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Outputs; the pipeline response is held quiet while reset is asserted
  always_comb begin
    mem_req        = mem_req_q;
    mem_we         = mem_we_q;
    mem_addr       = mem_addr_q;
    mem_wdata      = mem_wdata_q;
    Dcache_bus_out = Rst ? {miss, rdata} : '0;
  end

endmodule
